// File: rtl/instr_mem_pkg.sv
// Shared types and constants for the instruction-memory fetch path.
package instr_mem_pkg;

  localparam logic [31:0] NOP_INSTR    = 32'h00000013;
  localparam int          RESP_ADDR_W  = 32;

  typedef enum logic [1:0] {
    FAULT_NONE     = 2'b00,
    FAULT_MISALIGN = 2'b01,
    FAULT_RANGE    = 2'b10
  } fault_e;

  // Address field is sized for the widest supported ADDR_W.
  typedef struct packed {
    logic [31:0]            instr;
    logic [RESP_ADDR_W-1:0] addr;
    fault_e                 fault;
  } resp_t;

endpackage

// File: rtl/instr_mem_fetch_fifo.sv
// Two-entry in-order response FIFO; head is always presented on o_head.
module resp_fifo2
  import instr_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_flush,
  input  logic       i_push,
  input  resp_t      i_data,
  input  logic       i_pop,
  output resp_t      o_head,
  output logic [1:0] o_count,
  output logic       o_full,
  output logic       o_empty
);

  resp_t      r_entry [2];
  logic       r_wptr;
  logic       r_rptr;
  logic [1:0] r_count;
  logic       w_push;
  logic       w_pop;

  assign o_full  = (r_count == 2'd2);
  assign o_empty = (r_count == 2'd0);
  assign o_count = r_count;
  assign o_head  = r_entry[r_rptr];

  // Push into a full FIFO is allowed only when the head leaves in the same cycle.
  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_entry[0] <= '0;
      r_entry[1] <= '0;
      r_wptr     <= 1'b0;
      r_rptr     <= 1'b0;
      r_count    <= '0;
    end else if (i_flush) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_entry[r_wptr] <= i_data;
        r_wptr          <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;
      r_count <= r_count + 2'(w_push) - 2'(w_pop);
    end
  end

endmodule

// File: rtl/instr_mem_fetch.sv
// Handshaked instruction memory: registered read, fault checks, 2-entry response buffer.
module instr_mem_fetch
  import instr_mem_pkg::*;
#(
  parameter int DEPTH     = 256,
  parameter int ADDR_W    = 32,
  parameter     INIT_FILE = ""
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_W-1:0]        req_addr,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [31:0]              resp_instr,
  output logic [ADDR_W-1:0]        resp_addr,
  output logic [1:0]               resp_fault,
  input  logic                     flush,
  input  logic                     ld_en,
  input  logic [$clog2(DEPTH)-1:0] ld_addr,
  input  logic [31:0]              ld_data
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [31:0]       r_mem [DEPTH];
  logic              r_rd_valid;
  logic [ADDR_W-1:0] r_rd_addr;
  fault_e            r_rd_fault;
  logic [31:0]       r_rd_word;

  logic [IDX_W-1:0]  w_idx;
  fault_e            w_fault;
  logic              w_accept;
  logic              w_pop;
  logic [2:0]        w_used;
  resp_t             w_push_data;
  resp_t             w_head;
  logic [1:0]        w_fifo_count;
  logic              w_fifo_full;
  logic              w_fifo_empty;

  assign w_idx = req_addr[2 +: IDX_W];

  always_comb begin
    w_fault = FAULT_NONE;
    if (req_addr[1:0] != 2'b00)                   w_fault = FAULT_MISALIGN;
    else if (req_addr[ADDR_W-1:IDX_W+2] != '0)    w_fault = FAULT_RANGE;
  end

  // Credit check: slots committed after this cycle's pop must leave room for one more.
  assign w_pop     = resp_valid && resp_ready;
  assign w_used    = 3'(w_fifo_count) + 3'(r_rd_valid) - 3'(w_pop);
  assign req_ready = !flush && (w_used < 3'd2);
  assign w_accept  = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (ld_en) r_mem[ld_addr] <= ld_data;
    if (w_accept && w_fault == FAULT_NONE) r_rd_word <= r_mem[w_idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_valid <= 1'b0;
      r_rd_addr  <= '0;
      r_rd_fault <= FAULT_NONE;
    end else begin
      r_rd_valid <= w_accept;
      if (w_accept) begin
        r_rd_addr  <= req_addr;
        r_rd_fault <= w_fault;
      end
    end
  end

  always_comb begin
    w_push_data       = '0;
    w_push_data.instr = (r_rd_fault == FAULT_NONE) ? r_rd_word : NOP_INSTR;
    w_push_data.addr  = RESP_ADDR_W'(r_rd_addr);
    w_push_data.fault = r_rd_fault;
  end

  resp_fifo2 u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (flush),
    .i_push  (r_rd_valid && !flush),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_fifo_count),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign resp_valid = !w_fifo_empty;
  assign resp_instr = w_head.instr;
  assign resp_addr  = w_head.addr[ADDR_W-1:0];
  assign resp_fault = w_head.fault;

  // The credit logic must never let the read stage push into a full, non-popping FIFO.
  always_ff @(posedge clk) begin
    if (rst_n) assert (!(w_fifo_full && r_rd_valid && !w_pop && !flush));
  end

endmodule

// File: tb/tb_instr_mem_fetch.sv
// Directed bench for instr_mem_fetch with hand-computed expectations.
module tb_instr_mem_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_instr;
  logic [31:0] resp_addr;
  logic [1:0]  resp_fault;
  logic        flush;
  logic        ld_en;
  logic [7:0]  ld_addr;
  logic [31:0] ld_data;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] w_img [9];

  instr_mem_fetch #(.DEPTH(256), .ADDR_W(32), .INIT_FILE("")) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_instr (resp_instr),
    .resp_addr  (resp_addr),
    .resp_fault (resp_fault),
    .flush      (flush),
    .ld_en      (ld_en),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_resp(input string tag, input logic [31:0] instr,
                          input logic [31:0] addr, input logic [1:0] fault);
    chk({tag, ".valid"}, 64'(resp_valid), 64'd1);
    chk({tag, ".instr"}, 64'(resp_instr), 64'(instr));
    chk({tag, ".addr"},  64'(resp_addr),  64'(addr));
    chk({tag, ".fault"}, 64'(resp_fault), 64'(fault));
  endtask

  // Single fetch into an empty pipeline; response is checked one cycle after accept.
  task automatic fetch_check(input string tag, input logic [31:0] addr,
                             input logic [31:0] instr, input logic [1:0] fault);
    req_valid  = 1'b1;
    req_addr   = addr;
    resp_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    chk_resp(tag, instr, addr, fault);
    tick();
    chk({tag, ".drained"}, 64'(resp_valid), 64'd0);
  endtask

  initial begin
    w_img[0] = 32'h00A00093; w_img[1] = 32'h01400113;
    w_img[2] = 32'h02800193; w_img[3] = 32'h05000213;
    w_img[4] = 32'h00000000; w_img[5] = 32'h11111111;
    w_img[6] = 32'h00000000; w_img[7] = 32'h00000000;
    w_img[8] = 32'h00800413;

    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; resp_ready = 1'b1;
    flush = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    tick(); tick();
    rst_n = 1'b1;
    #1;
    chk("rst.valid", 64'(resp_valid), 64'd0);
    chk("rst.instr", 64'(resp_instr), 64'd0);
    chk("rst.addr",  64'(resp_addr),  64'd0);
    chk("rst.fault", 64'(resp_fault), 64'd0);
    chk("rst.ready", 64'(req_ready),  64'd1);

    for (int unsigned i = 0; i < 9; i++) begin
      ld_en = 1'b1; ld_addr = 8'(i); ld_data = w_img[i];
      tick();
    end
    ld_en = 1'b0;

    // Back-to-back stream
    for (int unsigned i = 0; i < 4; i++) begin
      req_valid = 1'b1; req_addr = 32'(4 * i);
      tick();
      if (i > 0) chk_resp($sformatf("stream%0d", i - 1), w_img[i-1], 32'(4 * (i - 1)), 2'b00);
    end
    req_valid = 1'b0;
    tick();
    chk_resp("stream3", w_img[3], 32'hC, 2'b00);
    tick();
    chk("stream.end", 64'(resp_valid), 64'd0);

    // Backpressure
    resp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h0;
    #1 chk("bp.rdy0", 64'(req_ready), 64'd1);
    tick();
    req_addr = 32'h4;
    #1 chk("bp.rdy1", 64'(req_ready), 64'd1);
    tick();
    req_addr = 32'h8;
    #1 chk("bp.rdy2", 64'(req_ready), 64'd0);
    tick();
    chk("bp.rdy3", 64'(req_ready), 64'd0);
    chk_resp("bp.hold", w_img[0], 32'h0, 2'b00);
    tick();
    chk_resp("bp.stable", w_img[0], 32'h0, 2'b00);
    resp_ready = 1'b1;
    #1 chk("bp.rdy_pop", 64'(req_ready), 64'd1);
    tick();
    req_valid = 1'b0;
    chk_resp("bp.r1", w_img[1], 32'h4, 2'b00);
    tick();
    chk_resp("bp.r2", w_img[2], 32'h8, 2'b00);
    tick();
    chk("bp.end", 64'(resp_valid), 64'd0);

    // Faults
    fetch_check("mis6",   32'h6,   32'h00000013, 2'b01);
    fetch_check("rng400", 32'h400, 32'h00000013, 2'b10);
    fetch_check("mis402", 32'h402, 32'h00000013, 2'b01);

    // Loader write colliding with fetch of the same word
    ld_en = 1'b1; ld_addr = 8'd5; ld_data = 32'hDEADBEEF;
    req_valid = 1'b1; req_addr = 32'h14; resp_ready = 1'b1;
    tick();
    ld_en = 1'b0; req_valid = 1'b0;
    tick();
    chk_resp("ld.old", 32'h11111111, 32'h14, 2'b00);
    tick();
    fetch_check("ld.new", 32'h14, 32'hDEADBEEF, 2'b00);

    // Flush with two buffered responses
    resp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h0;
    tick();
    req_addr = 32'h4;
    tick();
    req_valid = 1'b0;
    tick();
    chk("fl.pre", 64'(resp_valid), 64'd1);
    flush = 1'b1;
    #1 chk("fl.rdy", 64'(req_ready), 64'd0);
    tick();
    flush = 1'b0;
    chk("fl.valid", 64'(resp_valid), 64'd0);
    #1 chk("fl.rdy_after", 64'(req_ready), 64'd1);
    fetch_check("fl.new", 32'h20, w_img[8], 2'b00);

    // Asynchronous reset mid-stream
    resp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h4;
    tick();
    req_addr = 32'h8;
    tick();
    req_valid = 1'b0;
    chk_resp("ar.pre", w_img[1], 32'h4, 2'b00);
    #2 rst_n = 1'b0;
    #1;
    chk("ar.valid", 64'(resp_valid), 64'd0);
    chk("ar.addr",  64'(resp_addr),  64'd0);
    chk("ar.instr", 64'(resp_instr), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("ar.ready", 64'(req_ready),  64'd1);
    chk("ar.empty", 64'(resp_valid), 64'd0);
    fetch_check("ar.memkept", 32'h0, w_img[0], 2'b00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
